// File: rtl/spectrum_fetch_if.sv
// Writer handshake and single-port bin RAM bus shared by the fetch scheduler.
// The scheduler owns the RAM side (master); the writer/RAM environment is the slave.
interface spectrum_fetch_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BIN_W  = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [BIN_W-1:0]  wr_data;
  logic              wr_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [BIN_W-1:0]  ram_wdata;
  logic [BIN_W-1:0]  ram_rdata;

  modport master (
    input  wr_req, wr_addr, wr_data, ram_rdata,
    output wr_ack, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, ram_rdata,
    input  wr_ack, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/spectrum_fetch_scheduler.sv
// Shares the bin RAM between the FFT writer and a once-per-frame snapshot into a
// shadow bank taken at the first cycle of vertical blanking. The renderer reads the
// shadow bank, so bar heights never change mid-frame.
module spectrum_fetch_scheduler #(
  parameter int unsigned NBINS  = 32,
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              vgaclk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  spectrum_fetch_if.master  bus,
  input  logic [ADDR_W-1:0] bin_sel,
  output logic [BIN_W-1:0]  bin_mag,
  output logic              frame_ready,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned IdxW = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int unsigned AW1  = ADDR_W + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBINS - 1);
  localparam logic [AW1-1:0]  NbinsW  = AW1'(NBINS);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   k_q, k_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [BIN_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              frame_ready_q, frame_ready_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              rd_pend_q;
  logic [IdxW-1:0]   rd_idx_q;
  logic [BIN_W-1:0]  shadow_q [NBINS];
  logic              trigger;

  // First pixel of vertical blanking.
  assign trigger = (hc == 10'd0) && (vc == 10'd480);

  // Next-state and registered-output decode; k_q is the index being read this cycle.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    wr_ack_d      = 1'b0;
    frame_ready_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d    = StFetch;
          k_d        = '0;
          ram_en_d   = 1'b1;
          ram_addr_d = '0;
        end else if (bus.wr_req && !wr_ack_q) begin
          // wr_ack_q masks the request still held during the ack cycle.
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = bus.wr_addr;
          ram_wdata_d = bus.wr_data;
          wr_ack_d    = 1'b1;
        end
      end
      StFetch: begin
        if (k_q == LastIdx) begin
          state_d = StDrain;
        end else begin
          k_d        = k_q + IdxW'(1);
          ram_en_d   = 1'b1;
          ram_addr_d = ADDR_W'(k_q + IdxW'(1));
        end
      end
      StDrain: begin
        state_d       = StIdle;
        frame_ready_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and RAM-side output registers.
  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      state_q       <= StIdle;
      k_q           <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      wr_ack_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      wr_ack_q      <= wr_ack_d;
      frame_ready_q <= frame_ready_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Capture read data one cycle after each fetch read into the shadow bank.
  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
      for (int i = 0; i < int'(NBINS); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      rd_pend_q <= (state_q == StFetch);
      rd_idx_q  <= k_q;
      if (rd_pend_q) begin
        shadow_q[rd_idx_q] <= bus.ram_rdata;
      end
    end
  end

  // Renderer lookup; selects past the last bin read as zero.
  always_comb begin
    bin_mag = '0;
    if ({1'b0, bin_sel} < NbinsW) begin
      bin_mag = shadow_q[bin_sel[IdxW-1:0]];
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.wr_ack    = wr_ack_q;
  assign frame_ready   = frame_ready_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
